// File: rtl/modsq_result_normalizer.sv
// Carry-propagating normalizer: redundant 17-bit coefficients to canonical words.
// Define MODSQ_NORM_DUAL_EN to resolve two coefficients per NORM cycle.
module modsq_result_normalizer #(
  parameter int MOD_LEN      = 1024,
  parameter int WORD_LEN     = 16,
  parameter int NUM_ELEMENTS = MOD_LEN/WORD_LEN+2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_valid,
  input  logic [NUM_ELEMENTS*2*WORD_LEN-1:0] in_coeffs,
  output logic                             in_ready,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [NUM_ELEMENTS*WORD_LEN-1:0] out_data,
  output logic                             out_overflow,
  output logic                             in_dropped
);

  localparam int LANE = 2*WORD_LEN;
  localparam int IW   = $clog2(NUM_ELEMENTS+1);

  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

  state_t              state;
  logic [WORD_LEN:0]   coef [NUM_ELEMENTS];
  logic [1:0]          carry;
  logic [IW-1:0]       idx;
  logic [WORD_LEN+1:0] s0;
  logic [1:0]          cout;
  logic                last;
  logic                accept;
  logic                unused_lanes;

  // upper lane bits carry no information
  assign unused_lanes = ^in_coeffs;
  assign accept = in_valid && (state == IDLE);

  always_comb begin
    s0 = {1'b0, coef[idx]} + {{WORD_LEN{1'b0}}, carry};
  end

`ifdef MODSQ_NORM_DUAL_EN
  localparam int STEP = 2;
  logic [IW-1:0]       idx_n1;
  logic [WORD_LEN+1:0] s1;
  always_comb begin
    idx_n1 = idx + IW'(1);
    s1 = {1'b0, coef[idx_n1]}
       + {{WORD_LEN{1'b0}}, s0[WORD_LEN+1:WORD_LEN]};
  end
  assign cout = s1[WORD_LEN+1:WORD_LEN];
`else
  localparam int STEP = 1;
  assign cout = s0[WORD_LEN+1:WORD_LEN];
`endif

  assign last = (idx == IW'(NUM_ELEMENTS-STEP));

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int j = 0; j < NUM_ELEMENTS; j++)
        coef[j] <= in_coeffs[j*LANE +: WORD_LEN+1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      out_overflow <= 1'b0;
      in_dropped   <= 1'b0;
      out_data     <= '0;
      carry        <= '0;
      idx          <= '0;
    end else begin
      if (in_valid && state != IDLE)
        in_dropped <= 1'b1;
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            state    <= NORM;
            in_ready <= 1'b0;
            carry    <= '0;
            idx      <= '0;
          end
        end
        NORM: begin
          out_data[int'(idx)*WORD_LEN +: WORD_LEN] <= s0[WORD_LEN-1:0];
`ifdef MODSQ_NORM_DUAL_EN
          out_data[(int'(idx)+1)*WORD_LEN +: WORD_LEN] <= s1[WORD_LEN-1:0];
`endif
          carry <= cout;
          idx   <= idx + IW'(STEP);
          if (last) begin
            state        <= DONE;
            out_valid    <= 1'b1;
            out_overflow <= (cout != 2'd0);
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/modsq_result_normalizer.md
MODSQ_RESULT_NORMALIZER -- requirements
Module: modsq_result_normalizer

Interface
REQ-001 SHALL have parameter MOD_LEN, default 1024, modulus width in bits.
REQ-002 SHALL have parameter WORD_LEN, default 16, coefficient radix width.
REQ-003 SHALL have parameter NUM_ELEMENTS, default MOD_LEN/WORD_LEN+2, number of redundant coefficients; must be even.
REQ-004 SHALL have port clk, input, 1, clock; reset is synchronous, active-high, on rising clk.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port in_valid, input, 1, single-cycle pulse marking in_coeffs valid.
REQ-007 SHALL have port in_coeffs, input, NUM_ELEMENTS*2*WORD_LEN, coefficient j in lane [j*32 +: 32]; only bits [16:0] of each lane are used.
REQ-008 SHALL have port in_ready, output, 1, high when IDLE.
REQ-009 SHALL have port out_valid, output, 1, normalized result available.
REQ-010 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-011 SHALL have port out_data, output, NUM_ELEMENTS*WORD_LEN, canonical integer sum of c_j*2^(WORD_LEN*j) truncated.
REQ-012 SHALL have port out_overflow, output, 1, final carry nonzero.
REQ-013 SHALL have port in_dropped, output, 1, sticky flag: in_valid seen while not in_ready.

Function
REQ-014 SHALL implement states IDLE, NORM, DONE.
REQ-015 IDLE: in_valid=1 SHALL latch all coefficients, clear carry and index, go to NORM.
REQ-016 NORM: each cycle SHALL compute s = c_idx[16:0] + carry, write s[15:0] to out_data word idx, carry <= s>>16 (2-bit register), idx++.
REQ-017 NORM SHALL exit to DONE after the cycle processing idx = NUM_ELEMENTS-1; out_overflow <= (final carry != 0).
REQ-018 DONE: out_valid=1, out_data/out_overflow held stable until out_valid & out_ready, then IDLE in next cycle.
REQ-019 Latency: in_valid accepted cycle t -> out_valid first high at t+NUM_ELEMENTS+1 (serial mode).
REQ-020 in_valid while in NORM or DONE SHALL be ignored (no data change) and set in_dropped.
REQ-021 out_ready while out_valid=0 SHALL have no effect; out_valid SHALL not drop without handshake.
REQ-022 in_ready SHALL be 1 only in IDLE; the accepting cycle sees in_ready=1.
REQ-023 Carry SHALL never exceed 2; bits [31:17] of each lane SHALL be ignored.

Reset
REQ-024 reset SHALL force IDLE, in_ready=1, out_valid=0, out_overflow=0, in_dropped=0, out_data=0, carry=0, idx=0.
REQ-025 reset mid-NORM or mid-DONE SHALL abandon the result; no out_valid for that operand.
REQ-026 reset SHALL take priority over in_valid in the same cycle.

Configuration
REQ-027 Macro MODSQ_NORM_DUAL_EN defined SHALL process two coefficients per NORM cycle (chained carry), latency t+NUM_ELEMENTS/2+1.
REQ-028 MODSQ_NORM_DUAL_EN undefined SHALL give serial one-coefficient-per-cycle operation per REQ-016/019.
REQ-029 out_data and out_overflow SHALL be bit-identical in both modes.

Verification
REQ-030 All coefficients 0, in_valid pulse -> out_valid at t+67 (defaults), out_data=0, out_overflow=0.
REQ-031 c0=0x1FFFF, others 0 -> out_data word0=0xFFFF, word1=0x0001, rest 0, out_overflow=0.
REQ-032 c0=0x10000, c1..c65=0x0FFFF -> carry ripples, out_data=0, out_overflow=1.
REQ-033 out_ready held low 10 cycles after out_valid -> out_valid/out_data stable; second in_valid in that window -> in_dropped=1, result unchanged.
REQ-034 reset asserted mid-NORM (idx=20) -> next cycle in_ready=1, out_valid=0, no result emitted; fresh operand then completes normally.
REQ-035 Same random operands with MODSQ_NORM_DUAL_EN on/off -> identical out_data/out_overflow, latency 34 vs 67 cycles.
